// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions for the 5-stage MIPS core.
// Decode reuses the IF/ID bundle type.
package fetch_stage_pkg;

  localparam int PC_W = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic            valid;
    logic [31:0]     instr;
    logic [PC_W-1:0] pc;
  } ifid_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding register for a fetch that returns while the pipe is paused.
// Flush has priority over load, and load has priority over consume.
module fetch_skid_buf
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] NOP = NOP_INSTR
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            flush,
  input  logic            load,
  input  logic            consume,
  input  logic [31:0]     load_instr,
  input  logic [PC_W-1:0] load_pc,
  output logic            valid,
  output logic [31:0]     instr,
  output logic [PC_W-1:0] pc
);

  always_ff @(posedge clk) begin
    if (!rstn || flush) begin
      valid <= 1'b0;
      instr <= NOP;
      pc    <= '0;
    end else if (load) begin
      valid <= 1'b1;
      instr <= load_instr;
      pc    <= load_pc;
    end else if (consume) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues synchronous imem reads, and holds IF/ID.
// Redirects take priority over pause, and pause takes priority over advance.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0]     NOP      = NOP_INSTR
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            i_FetchStage_pause,
  input  logic            i_FetchStage_redirect,
  input  logic [PC_W-1:0] i_FetchStage_target,
  output logic            o_FetchStage_imemEn,
  output logic [PC_W-1:0] o_FetchStage_imemAddr,
  input  logic [31:0]     i_FetchStage_imemRData,
  output logic            o_FetchStage_ifidValid,
  output logic [31:0]     o_FetchStage_ifidInstr,
  output logic [PC_W-1:0] o_FetchStage_ifidPc,
  output logic [PC_W-1:0] o_FetchStage_ifidPc4
);

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] inflight_pc_q;
  logic            inflight_q;
  ifid_t           ifid_q;
  ifid_t           fill;

  logic            skid_valid;
  logic [31:0]     skid_instr;
  logic [PC_W-1:0] skid_pc;
  logic            skid_load;
  logic            skid_consume;
  logic            advance;

  assign advance      = !i_FetchStage_redirect && !i_FetchStage_pause;
  assign skid_load    = !i_FetchStage_redirect && i_FetchStage_pause && inflight_q;
  assign skid_consume = advance && skid_valid;

  assign o_FetchStage_imemEn    = rstn && advance;
  assign o_FetchStage_imemAddr  = pc_q;
  assign o_FetchStage_ifidValid = ifid_q.valid;
  assign o_FetchStage_ifidInstr = ifid_q.instr;
  assign o_FetchStage_ifidPc    = ifid_q.pc;
  assign o_FetchStage_ifidPc4   = ifid_q.pc + 32'd4;

  fetch_skid_buf #(.NOP(NOP)) u_skid (
    .clk        (clk),
    .rstn       (rstn),
    .flush      (i_FetchStage_redirect),
    .load       (skid_load),
    .consume    (skid_consume),
    .load_instr (i_FetchStage_imemRData),
    .load_pc    (inflight_pc_q),
    .valid      (skid_valid),
    .instr      (skid_instr),
    .pc         (skid_pc)
  );

  // A parked skid entry is always older than anything in flight, so it goes first.
  always_comb begin
    fill = '{valid: 1'b0, instr: NOP, pc: ifid_q.pc};
    if (skid_valid) begin
      fill = '{valid: 1'b1, instr: skid_instr, pc: skid_pc};
    end else if (inflight_q) begin
      fill = '{valid: 1'b1, instr: i_FetchStage_imemRData, pc: inflight_pc_q};
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      ifid_q        <= '{valid: 1'b0, instr: NOP, pc: '0};
    end else if (i_FetchStage_redirect) begin
      pc_q         <= i_FetchStage_target & ~32'd3;
      inflight_q   <= 1'b0;
      ifid_q.valid <= 1'b0;
      ifid_q.instr <= NOP;
    end else if (i_FetchStage_pause) begin
      inflight_q <= 1'b0;
    end else begin
      ifid_q        <= fill;
      pc_q          <= pc_q + 32'd4;
      inflight_q    <= 1'b1;
      inflight_pc_q <= pc_q;
    end
  end

  // Reads are suppressed while paused, so a parked entry can never coexist with a read in flight.
  assert property (@(posedge clk) disable iff (!rstn) !(skid_valid && inflight_q));

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios followed by random pause/redirect/reset traffic.
// The reference model tracks one pending fetch per cycle, not the RTL's inflight/skid split.
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_I  = 32'h0000_0020;

  logic        clk = 1'b0;
  logic        rstn;
  logic        pause;
  logic        redirect;
  logic [31:0] target;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc4;

  int checks = 0;
  int failures = 0;

  bit [31:0] m_next_pc;
  bit        m_held_v;
  bit [31:0] m_held_pc;
  bit        m_ifid_v;
  bit [31:0] m_ifid_instr;
  bit [31:0] m_ifid_pc;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(RST_PC), .NOP(NOP_I)) dut (
    .clk                    (clk),
    .rstn                   (rstn),
    .i_FetchStage_pause     (pause),
    .i_FetchStage_redirect  (redirect),
    .i_FetchStage_target    (target),
    .o_FetchStage_imemEn    (imem_en),
    .o_FetchStage_imemAddr  (imem_addr),
    .i_FetchStage_imemRData (imem_rdata),
    .o_FetchStage_ifidValid (ifid_valid),
    .o_FetchStage_ifidInstr (ifid_instr),
    .o_FetchStage_ifidPc    (ifid_pc),
    .o_FetchStage_ifidPc4   (ifid_pc4)
  );

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // Synchronous instruction memory; data holds when not enabled.
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= memf(imem_addr);
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    m_next_pc    = RST_PC;
    m_held_v     = 1'b0;
    m_held_pc    = '0;
    m_ifid_v     = 1'b0;
    m_ifid_instr = NOP_I;
    m_ifid_pc    = '0;
  endtask

  // Every issued fetch shows up exactly once in IF/ID, in order, unless a redirect or reset drops it.
  task automatic modelStep(input bit r, input bit p, input bit rd, input bit [31:0] t);
    if (!r) begin
      modelReset();
    end else if (rd) begin
      m_next_pc    = {t[31:2], 2'b00};
      m_held_v     = 1'b0;
      m_ifid_v     = 1'b0;
      m_ifid_instr = NOP_I;
    end else if (!p) begin
      m_ifid_v = m_held_v;
      if (m_held_v) begin
        m_ifid_instr = memf(m_held_pc);
        m_ifid_pc    = m_held_pc;
      end else begin
        m_ifid_instr = NOP_I;
      end
      m_held_v  = 1'b1;
      m_held_pc = m_next_pc;
      m_next_pc = m_next_pc + 32'd4;
    end
  endtask

  task automatic applyStimulus(input bit r, input bit p, input bit rd, input bit [31:0] t);
    rstn     = r;
    pause    = p;
    redirect = rd;
    target   = t;
    #1;
    checkOutput("imemEn", {31'b0, imem_en}, {31'b0, r && !p && !rd});
    if (r) checkOutput("imemAddr", imem_addr, m_next_pc);
    @(posedge clk);
    modelStep(r, p, rd, t);
    #1;
    checkOutput("ifidValid", {31'b0, ifid_valid}, {31'b0, m_ifid_v});
    checkOutput("ifidInstr", ifid_instr, m_ifid_instr);
    checkOutput("ifidPc", ifid_pc, m_ifid_pc);
    checkOutput("ifidPc4", ifid_pc4, m_ifid_pc + 32'd4);
    @(negedge clk);
  endtask

  initial begin
    bit        r, p, rd;
    bit [31:0] t;
    rstn     = 1'b0;
    pause    = 1'b0;
    redirect = 1'b0;
    target   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    modelReset();

    $display("[TB] reset and streaming fetch");
    applyStimulus(0, 0, 0, 0);
    checkOutput("resetValid", {31'b0, ifid_valid}, 32'd0);
    checkOutput("resetInstr", ifid_instr, NOP_I);
    repeat (5) applyStimulus(1, 0, 0, 0);
    checkOutput("streamPc", ifid_pc, 32'h0000_000C);

    $display("[TB] pause with fetch of 0x10 in flight");
    repeat (3) applyStimulus(1, 1, 0, 0);
    checkOutput("frozenPc", ifid_pc, 32'h0000_000C);
    applyStimulus(1, 0, 0, 0);
    checkOutput("releasePc", ifid_pc, 32'h0000_0010);
    applyStimulus(1, 0, 0, 0);
    checkOutput("releaseNextPc", ifid_pc, 32'h0000_0014);

    $display("[TB] redirect to unaligned target");
    applyStimulus(1, 0, 1, 32'h0000_0103);
    checkOutput("redirectAddr", imem_addr, 32'h0000_0100);
    repeat (3) applyStimulus(1, 0, 0, 0);

    $display("[TB] redirect together with pause");
    applyStimulus(1, 1, 1, 32'h0000_0100);
    repeat (2) applyStimulus(1, 1, 0, 0);
    repeat (3) applyStimulus(1, 0, 0, 0);

    $display("[TB] PC wrap");
    applyStimulus(1, 0, 1, 32'hFFFF_FFFC);
    repeat (3) applyStimulus(1, 0, 0, 0);
    checkOutput("wrapPc", ifid_pc, 32'h0000_0000);

    $display("[TB] reset while paused with skid loaded");
    applyStimulus(1, 0, 0, 0);
    repeat (2) applyStimulus(1, 1, 0, 0);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("postResetAddr", imem_addr, RST_PC + 32'd4);
    repeat (3) applyStimulus(1, 0, 0, 0);

    $display("[TB] random traffic");
    for (int i = 0; i < 800; i++) begin
      r  = ($urandom_range(0, 49) != 0);
      p  = ($urandom_range(0, 3) == 0);
      rd = ($urandom_range(0, 9) == 0);
      t  = $urandom;
      if ($urandom_range(0, 7) == 0) t = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      applyStimulus(r, p, rd, t);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
